truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential stimulus/response engine for small combinational gate modules. It drives every input combination of an N-input, 1-output function, samples the function's output after a settle interval, and compares each sample against a parameterised expected truth table. It sits on the input side of the gate under test: it replaces the hand-written `x = 0; y = 0; #1; ...` sequence with a clocked sweep that self-checks and reports pass/fail.

## Interface
Parameters:
- `N`, default 2: number of function inputs; legal range 1..8.
- `EXPECT`, default `4'b0000`, width 2^N: expected output; bit i is the expected `s` for input vector i.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..255, 0 is illegal.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `x_out` out N: vector driven to the gate under test; `x_out[1]`=x, `x_out[0]`=y for N=2.
- `s_in` in 1: output of the gate under test.
- `busy` out 1: high while the sweep is in progress.
- `done` out 1: high from sweep completion until the next accepted `start` or `rst`.
- `pass` out 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` out N+1: number of mismatching vectors.
- `first_err_vec` out N: index of the first mismatch; 0 if none.
- `resp` out 2^N: captured response table; bit i = `s_in` sampled for vector i.

## Operation
- States:
  - IDLE: no sweep in progress.
  - DRIVE: holds the current vector; a settle counter runs `SETTLE` cycles.
  - SAMPLE: lasts 1 cycle; `s_in` is captured at the end edge.
  - DONE: sweep complete.
- IDLE/DONE, `start`=1 → DRIVE.
  - `vec`=0, settle counter=0.
  - `err_count`, `first_err_vec`, `resp` cleared; `done`=0, `pass`=0.
- DRIVE: when the counter reaches `SETTLE`-1, → SAMPLE.
- SAMPLE:
  - `resp[vec]` ← `s_in`.
  - On mismatch (`s_in` ≠ `EXPECT[vec]`): `err_count`+1; if this is the first mismatch, `first_err_vec` ← `vec`.
  - If `vec` = 2^N-1 → DONE; otherwise `vec`+1 → DRIVE. `vec` never wraps.
- DONE: `done`=1, `pass`=(`err_count`==0). Outputs hold until a new `start`.
- `x_out` = `vec`, registered; it changes only on the DRIVE entry edge.
- `err_count` is N+1 bits so it can hold 2^N without saturation.

## Timing
- Reset values: `x_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_vec`=0, `resp`=0; state IDLE.
- `start` sampled at edge k: `busy`=1 and `x_out`=0 after edge k.
- `done` rises after edge k+1+2^N·(SETTLE+1); `busy` falls on the same edge.
  - N=2, SETTLE=1: 9 edges after the start edge.
- Each vector is stable for exactly SETTLE+1 cycles; `s_in` is sampled on the last edge of that window.
- `start` while `busy`=1: ignored, no restart.
- `start` in DONE: new sweep, same timing as from IDLE.
- `rst` mid-sweep: all outputs return to reset values on that edge and the state goes to IDLE. `rst` has priority over `start` on the same edge.

## Configuration
- `SWEEP_STOP_ON_ERR_EN` defined:
  - The sweep terminates at the first mismatching SAMPLE and → DONE on that edge.
  - `err_count`=1, `first_err_vec` = the failing index, `pass`=0.
  - `resp` bits above the failing index remain 0.
- `SWEEP_STOP_ON_ERR_EN` undefined: all 2^N vectors are always swept and `err_count` counts every mismatch.

## Test plan
- N=2, EXPECT=0000, DUT s = y&~y&~(~x|x), SETTLE=1; `start` pulse → `done` after 9 cycles, `pass`=1, `err_count`=0, `resp`=0000, `x_out` sequence 0,1,2,3.
- N=2, EXPECT=0110, DUT s=x^y → `pass`=1, `resp`=0110.
- N=2, EXPECT=0110, DUT s=0, macro undefined → `pass`=0, `err_count`=2, `first_err_vec`=1, `resp`=0000.
- Same as the previous case with `SWEEP_STOP_ON_ERR_EN` defined → `done` 5 cycles after start (after the vector-1 sample), `err_count`=1, `first_err_vec`=1.
- `start` re-pulsed while `busy` → no timing change. Then `rst`=1 at cycle 4 → all outputs 0, IDLE. A new `start` then runs a full clean 9-cycle sweep.
- SETTLE=3, N=2 → each `x_out` value held 4 cycles, `done` after 17 cycles.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Clocked stimulus/response engine for an N-input, 1-output combinational
// gate. It walks x_out through every input vector, holds each vector for
// SETTLE+1 cycles, samples s_in on the last edge of that window, and checks
// the sample against the EXPECT truth table.
//
// Optional build macro: SWEEP_STOP_ON_ERR_EN. When it is defined, the sweep
// ends at the first mismatching sample. When it is undefined, all 2^N vectors
// are always swept.
//
// Handshake: start is a level that is sampled only while the engine is idle,
// which means state IDLE or DONE with busy low. A start seen while busy is
// high is dropped. done stays high from the end of a sweep until the next
// accepted start or rst. pass, err_count, first_err_vec and resp are final
// whenever done is high.
//
// fsm_state exposes the controller state: 0 IDLE, 1 DRIVE, 2 SAMPLE, 3 DONE.
// busy and done are registered, so they change one edge after the FSM
// reaches DONE.
module truth_table_sweeper #(
  parameter int                    N      = 2,
  parameter logic [(2**N)-1:0]     EXPECT = '0,
  parameter int                    SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N-1:0]        x_out,
  input  logic                s_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N:0]          err_count,
  output logic [N-1:0]        first_err_vec,
  output logic [(2**N)-1:0]   resp,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [N-1:0] VEC_ONE = N'(1);
  localparam logic [N:0]   ERR_ONE = (N+1)'(1);
  localparam logic [7:0]   CNT_END = 8'(SETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;

  logic accept;
  logic sample;
  logic mismatch;
  logic last_vec;
  logic settle_end;
  logic stop_now;
  logic finish;

  // x_out doubles as the current vector index.
  assign last_vec = &x_out;

`ifdef SWEEP_STOP_ON_ERR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (accept) next_state = ST_DRIVE;
      ST_DRIVE:         if (settle_end) next_state = ST_SAMPLE;
      ST_SAMPLE:        next_state = (last_vec || stop_now) ? ST_DONE : ST_DRIVE;
      default:          next_state = ST_IDLE;
    endcase
  end

  // Control strobes derived from the current state.
  always_comb begin
    accept     = 1'b0;
    sample     = 1'b0;
    settle_end = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:   accept = start && !busy;
      ST_DONE: begin
        accept = start && !busy;
        finish = busy;
      end
      ST_DRIVE:  settle_end = (cnt == CNT_END);
      ST_SAMPLE: sample = 1'b1;
      default: ;
    endcase
    mismatch = sample && (s_in != EXPECT[x_out]);
    fsm_state = state;
  end

  // Vector, settle counter, response capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out         <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      resp          <= '0;
    end else begin
      if (accept) begin
        x_out         <= '0;
        cnt           <= '0;
        busy          <= 1'b1;
        done          <= 1'b0;
        pass          <= 1'b0;
        err_count     <= '0;
        first_err_vec <= '0;
        resp          <= '0;
      end
      if (state == ST_DRIVE) cnt <= cnt + 8'd1;
      if (sample) begin
        resp[x_out] <= s_in;
        if (mismatch) begin
          err_count <= err_count + ERR_ONE;
          if (err_count == '0) first_err_vec <= x_out;
        end
        // The vector index stops at the last vector and never wraps.
        if (!last_vec && !stop_now) begin
          x_out <= x_out + VEC_ONE;
          cnt   <= '0;
        end
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// This bench uses three sweeper instances on one clock:
//   u0: N=2, EXPECT=0000, SETTLE=1, gate s = y & ~y & ~(~x | x), which is constant 0
//   u1: N=2, EXPECT=0110, SETTLE=1, gate s = x ^ y, or constant 0 when xor_mode is low
//   u2: N=2, EXPECT=0000, SETTLE=3, gate s = constant-0 expression
// Expected values are computed by hand from the sweep timing:
//   done rises after edge k + 1 + 4*(SETTLE+1).
//   Vector v is driven from edge k + v*(SETTLE+1).
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       xor_mode = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] s_v;
  logic [2:0] busy_v, done_v, pass_v;
  logic [1:0] x_v     [3];
  logic [2:0] err_v   [3];
  logic [1:0] first_v [3];
  logic [3:0] resp_v  [3];
  logic [1:0] st_v    [3];

  int total = 0;
  int bad   = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  // Gates under test: the y = x_out[0] and x = x_out[1] mapping.
  assign s_v[0] = x_v[0][0] & ~x_v[0][0] & ~(~x_v[0][1] | x_v[0][1]);
  assign s_v[1] = xor_mode ? (x_v[1][1] ^ x_v[1][0]) : 1'b0;
  assign s_v[2] = x_v[2][0] & ~x_v[2][0];

  truth_table_sweeper #(.N(2), .EXPECT(4'b0000), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .x_out(x_v[0]), .s_in(s_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .first_err_vec(first_v[0]), .resp(resp_v[0]), .fsm_state(st_v[0]));

  truth_table_sweeper #(.N(2), .EXPECT(4'b0110), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .x_out(x_v[1]), .s_in(s_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .first_err_vec(first_v[1]), .resp(resp_v[1]), .fsm_state(st_v[1]));

  truth_table_sweeper #(.N(2), .EXPECT(4'b0000), .SETTLE(3)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .x_out(x_v[2]), .s_in(s_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .first_err_vec(first_v[2]), .resp(resp_v[2]), .fsm_state(st_v[2]));

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
  endtask

  // Count edges until done, up to a bound. The count continues from n_in.
  task automatic wait_done(input int i, input int n_in, output int n);
    n = n_in;
    while (done_v[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || pass_v[i] !== 1'b0 ||
          x_v[i] !== 2'd0 || err_v[i] !== 3'd0 || first_v[i] !== 2'd0 ||
          resp_v[i] !== 4'd0 || st_v[i] !== 2'd0) begin
        bad++;
        $display("FAIL reset u%0d: busy=%b done=%b pass=%b x=%0d err=%0d first=%0d resp=%b st=%0d, required all 0",
                 i, busy_v[i], done_v[i], pass_v[i], x_v[i], err_v[i], first_v[i], resp_v[i], st_v[i]);
      end
    end
  endtask

  task automatic test_clean_sweep();
    int exp_x;
    pulse_start(0);
    total++;
    if (busy_v[0] !== 1'b1 || x_v[0] !== 2'd0 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL clean_start: busy=%b x=%0d done=%b, required busy=1 x=0 done=0", busy_v[0], x_v[0], done_v[0]);
    end
    for (int j = 1; j <= 9; j++) begin
      tick();
      exp_x = (j / 2 > 3) ? 3 : j / 2;
      total++;
      if (x_v[0] !== 2'(exp_x)) begin
        bad++;
        $display("FAIL clean_x edge+%0d: x=%0d, required %0d", j, x_v[0], exp_x);
      end
      total++;
      if (done_v[0] !== (j == 9) || busy_v[0] !== (j < 9)) begin
        bad++;
        $display("FAIL clean_done edge+%0d: done=%b busy=%b, required done=%b busy=%b",
                 j, done_v[0], busy_v[0], (j == 9), (j < 9));
      end
    end
    total++;
    if (pass_v[0] !== 1'b1 || err_v[0] !== 3'd0 || resp_v[0] !== 4'b0000 || first_v[0] !== 2'd0) begin
      bad++;
      $display("FAIL clean_result: pass=%b err=%0d resp=%b first=%0d, required 1 0 0000 0",
               pass_v[0], err_v[0], resp_v[0], first_v[0]);
    end
  endtask

  task automatic test_xor();
    int n;
    xor_mode = 1'b1;
    pulse_start(1);
    wait_done(1, 0, n);
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL xor_latency: edges=%0d, required 9", n);
    end
    total++;
    if (pass_v[1] !== 1'b1 || resp_v[1] !== 4'b0110 || err_v[1] !== 3'd0) begin
      bad++;
      $display("FAIL xor_result: pass=%b resp=%b err=%0d, required 1 0110 0", pass_v[1], resp_v[1], err_v[1]);
    end
  endtask

  task automatic test_mismatch();
    int n;
    int exp_n;
    logic [2:0] exp_err;
`ifdef SWEEP_STOP_ON_ERR_EN
    exp_n = 5;
    exp_err = 3'd1;
`else
    exp_n = 9;
    exp_err = 3'd2;
`endif
    xor_mode = 1'b0;
    pulse_start(1);
    total++;
    if (done_v[1] !== 1'b0 || pass_v[1] !== 1'b0 || err_v[1] !== 3'd0 || resp_v[1] !== 4'd0 || busy_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: done=%b pass=%b err=%0d resp=%b busy=%b, required 0 0 0 0000 1",
               done_v[1], pass_v[1], err_v[1], resp_v[1], busy_v[1]);
    end
    wait_done(1, 0, n);
    total++;
    if (n !== exp_n) begin
      bad++;
      $display("FAIL mismatch_latency: edges=%0d, required %0d", n, exp_n);
    end
    total++;
    if (pass_v[1] !== 1'b0 || err_v[1] !== exp_err || first_v[1] !== 2'd1 || resp_v[1] !== 4'b0000) begin
      bad++;
      $display("FAIL mismatch_result: pass=%b err=%0d first=%0d resp=%b, required 0 %0d 1 0000",
               pass_v[1], err_v[1], first_v[1], resp_v[1], exp_err);
    end
  endtask

  task automatic test_busy_restart();
    int n;
    pulse_start(0);
    tick();
    pulse_start(0);
    wait_done(0, 2, n);
    total++;
    if (n !== 9 || pass_v[0] !== 1'b1 || err_v[0] !== 3'd0) begin
      bad++;
      $display("FAIL busy_restart: edges=%0d pass=%b err=%0d, required 9 1 0", n, pass_v[0], err_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_start(0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0 || x_v[0] !== 2'd0 ||
        err_v[0] !== 3'd0 || first_v[0] !== 2'd0 || resp_v[0] !== 4'd0 || st_v[0] !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b pass=%b x=%0d err=%0d first=%0d resp=%b st=%0d, required all 0",
               busy_v[0], done_v[0], pass_v[0], x_v[0], err_v[0], first_v[0], resp_v[0], st_v[0]);
    end
    rst = 1'b1;
    pulse_start(0);
    rst = 1'b0;
    total++;
    if (busy_v[0] !== 1'b0 || st_v[0] !== 2'd0) begin
      bad++;
      $display("FAIL rst_over_start: busy=%b st=%0d, required 0 0", busy_v[0], st_v[0]);
    end
    pulse_start(0);
    wait_done(0, 0, n);
    total++;
    if (n !== 9 || pass_v[0] !== 1'b1 || resp_v[0] !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_sweep: edges=%0d pass=%b resp=%b, required 9 1 0000", n, pass_v[0], resp_v[0]);
    end
  endtask

  task automatic test_settle3();
    int exp_x;
    pulse_start(2);
    total++;
    if (busy_v[2] !== 1'b1 || x_v[2] !== 2'd0) begin
      bad++;
      $display("FAIL settle3_start: busy=%b x=%0d, required 1 0", busy_v[2], x_v[2]);
    end
    for (int j = 1; j <= 17; j++) begin
      tick();
      exp_x = (j / 4 > 3) ? 3 : j / 4;
      total++;
      if (x_v[2] !== 2'(exp_x) || done_v[2] !== (j == 17)) begin
        bad++;
        $display("FAIL settle3 edge+%0d: x=%0d done=%b, required x=%0d done=%b", j, x_v[2], done_v[2], exp_x, (j == 17));
      end
    end
    total++;
    if (pass_v[2] !== 1'b1 || err_v[2] !== 3'd0) begin
      bad++;
      $display("FAIL settle3_result: pass=%b err=%0d, required 1 0", pass_v[2], err_v[2]);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_clean_sweep();
    test_xor();
    test_mismatch();
    test_busy_restart();
    test_reset_mid();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
